pp_row_accumulator: RTL and testbench
=====================================

# pp_row_accumulator

Sequential reduction stage directly downstream of the 16-bit Baugh-Wooley partial-product generator. Accepts one 16-bit partial-product row per handshake: rows 0..14 have the MSB already inverted, and row 15 arrives in the same generator form. The block applies row weighting and the row-15 complement, adds the Baugh-Wooley correction constant, and delivers the 32-bit two's-complement product through a valid/ready output. It is the area-minimal alternative to the combinational Dadda tree for low-throughput paths.

## Interface
- N, 16, operand width; the row input is N bits and the product is 2N bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  row_in holds a valid partial-product row.
- in_ready  output  1  block can accept a row this cycle.
- row_in  input  N  partial-product row in generator form: bits 0..N-2 = B_k&A_j, bit N-1 = ~(B_k&A_{N-1}).
- out_valid  output  1  product holds a completed result.
- out_ready  input  1  consumer accepts the product.
- product  output  2N  signed product A×B, two's complement.

## Operation
- States:
  - ACCUM: accepting rows.
  - DONE: holding the result.
- Internal registers:
  - row counter k, log2(N) bits.
  - accumulator acc, 2N bits.
  - output register product.
- Reset (async, rst_n=0):
  - state=ACCUM, k=0, acc=C where C = 2^N + 2^(2N-1) (0x8001_0000 for N=16).
  - product=0, out_valid=0, in_ready=1.
- ACCUM, per row transfer (in_valid && in_ready at a clock edge):
  - r = row_in for k<N-1; r = ~row_in (all N bits inverted) for k=N-1.
  - acc_next = acc + (zero-extend(r) << k), truncated mod 2^(2N); carries out of bit 2N-1 are discarded.
  - k increments.
- Final row (k=N-1 transfer):
  - product <= acc_next; state->DONE; out_valid=1.
  - acc <= C and k <= 0 in the same edge.
- ACCUM with in_valid=0: acc, k and state hold.
- DONE:
  - in_ready=0; product stable.
  - Leaves on an out_valid && out_ready edge: state->ACCUM, out_valid->0, product holds its last value.
- Rows must arrive in order k=0..N-1. The block does not reorder rows and has no row-index input.
- in_ready is a pure function of state: ACCUM=1, DONE=0. There is no combinational path from out_ready to in_ready.
- A reset at any point, including mid-accumulation or in DONE, discards the partial sum and any pending product.

## Timing
- Minimum latency: N transfer cycles; out_valid rises after the edge that accepts row N-1.
- DONE lasts at least 1 cycle. If out_ready=1 on the first DONE cycle, in_ready returns to 1 on the next cycle.
- Minimum period per product: N+1 cycles with continuous in_valid and out_ready.
- Backpressure: while out_ready=0, DONE holds indefinitely with product and out_valid stable.
- The input side tolerates in_valid gaps of any length between rows.
- Outputs in_ready, out_valid and product are registered or decoded only from state; there are no input-to-output combinational paths.

## Test plan
- 3×5:
  - Stimulus: rows 0 and 2 = 0x8003, all other rows 0x8000 (row 15 as sent = 0x8000).
  - Expect: product=0x0000_000F, out_valid after the 16th transfer.
- (-1)×(-1):
  - Stimulus: rows for A=0xFFFF, B=0xFFFF (rows 0..14 = 0x7FFF, row 15 sent = 0x7FFF).
  - Expect: product=0x0000_0001.
- Extremes:
  - 0x8000×0x8000: expect product=0x4000_0000.
  - 3×0xFFFE: expect product=0xFFFF_FFFA.
- Handshake stress:
  - Stimulus: random in_valid gaps plus out_ready held low for 10 cycles in DONE.
  - Expect: product stable and in_ready=0 throughout; the next product is correct after release.
- Mid-operation reset:
  - Stimulus: rst_n pulsed low after 7 rows, then a full 3×5 sequence.
  - Expect: out_valid=0 and product=0 immediately on reset; the following result is 0x0000_000F.
- Back-to-back:
  - Stimulus: 100 random operand pairs with out_ready=1.
  - Expect: each product matches the signed reference model, and one result arrives every 17 cycles.

Source files
------------

// File: rtl/pp_row_accumulator.sv
// Sequential Baugh-Wooley row reduction: accumulates N weighted partial-product
// rows into a 2N-bit signed product, delivered through a valid/ready output.
module pp_row_accumulator #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   row_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] KLAST = KW'(N - 1);
    // Baugh-Wooley correction constant 2^N + 2^(2N-1)
    localparam logic [2*N-1:0] CORR = {1'b1, {(N-2){1'b0}}, 1'b1, {N{1'b0}}};

    typedef enum logic {ACCUM, DONE} state_t;

    state_t         state;
    logic [KW-1:0]  k;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [N-1:0]   r;

    // The last row carries the sign weight, so it enters complemented.
    always_comb begin
        r        = (k == KLAST) ? ~row_in : row_in;
        acc_next = acc + ({{N{1'b0}}, r} << k);
    end

    assign in_ready = (state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            k         <= '0;
            acc       <= CORR;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (k == KLAST) begin
                            product   <= acc_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                            acc       <= CORR;
                            k         <= '0;
                        end else begin
                            acc <= acc_next;
                            k   <= k + KW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_pp_row_accumulator.sv
// Self-checking bench for pp_row_accumulator: table-driven products plus
// handshake, reset and back-to-back throughput sequences.
module tb_pp_row_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] row_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] product;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    pp_row_accumulator #(.N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_in    (row_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Generator-form row: bits 0..14 = B_k & A_j, bit 15 = ~(B_k & A_15)
    function automatic logic [15:0] gen_row(input logic [15:0] a, input logic [15:0] b, input int k);
        logic [15:0] r;
        for (int j = 0; j < 15; j++) r[j] = b[k] & a[j];
        r[15] = ~(b[k] & a[15]);
        return r;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    task automatic send_row(input logic [15:0] d, input int gap);
        int waited;
        repeat (gap) @(negedge clk);
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        in_valid = 1'b1;
        row_in   = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input int maxgap, input bit check_latency);
        for (int k = 0; k < 16; k++) begin
            send_row(gen_row(a, b, k), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
            if (check_latency && k == 14) chk("out_valid_before_last", {31'b0, out_valid}, 32'd0);
        end
        if (check_latency) chk("out_valid_after_last", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic wait_out(output bit ok);
        int waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        ok = out_valid;
        if (!ok) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_out(input logic [31:0] exp);
        out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_cleared", {31'b0, out_valid}, 32'd0);
        chk("product_held", product, exp);
        chk("in_ready_back", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    vec_t vecs[8];
    logic [15:0] ba[100];
    logic [15:0] bb[100];

    initial begin
        bit ok;
        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
        vecs[2] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[3] = '{16'h0003, 16'hFFFE, 32'hFFFF_FFFA};
        vecs[4] = '{16'h0000, 16'h0000, 32'h0000_0000};
        vecs[5] = '{16'h7FFF, 16'h8000, 32'hC000_8000};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
        vecs[7] = '{16'hFFFF, 16'h0001, 32'hFFFF_FFFF};

        #12;
        chk("reset_product", product, 32'd0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send_op(vecs[i].a, vecs[i].b, 0, 1'b1);
            wait_out(ok);
            chk($sformatf("vec%0d_product", i), product, vecs[i].exp);
            chk("done_in_ready", {31'b0, in_ready}, 32'd0);
            release_out(vecs[i].exp);
        end

        // Input gaps plus ten cycles of output backpressure
        send_op(16'h1234, 16'hFEDC, 3, 1'b0);
        wait_out(ok);
        for (int c = 0; c < 10; c++) begin
            chk("stall_product", product, ref_mul(16'h1234, 16'hFEDC));
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            @(negedge clk);
        end
        release_out(ref_mul(16'h1234, 16'hFEDC));
        send_op(16'hA5A5, 16'h0F0F, 2, 1'b0);
        wait_out(ok);
        chk("after_stall_product", product, ref_mul(16'hA5A5, 16'h0F0F));
        release_out(ref_mul(16'hA5A5, 16'h0F0F));

        // Reset after seven rows discards the partial sum and the held product
        for (int k = 0; k < 7; k++) send_row(gen_row(16'h4321, 16'h1111, k), 0);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midreset_product", product, 32'd0);
        chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send_op(16'h0003, 16'h0005, 0, 1'b0);
        wait_out(ok);
        chk("postreset_product", product, 32'h0000_000F);
        release_out(32'h0000_000F);

        // Back-to-back with continuous out_ready: one result per 17 cycles
        for (int i = 0; i < 100; i++) begin
            ba[i] = 16'($urandom);
            bb[i] = 16'($urandom);
        end
        ba[0] = 16'h8000; bb[0] = 16'h7FFF;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 100; i++) send_op(ba[i], bb[i], 0, 1'b0);
            end
            begin
                int prev;
                bit mok;
                prev = 0;
                for (int i = 0; i < 100; i++) begin
                    wait_out(mok);
                    if (!mok) break;
                    chk($sformatf("b2b%0d_product", i), product, ref_mul(ba[i], bb[i]));
                    if (i > 0) chk($sformatf("b2b%0d_period", i), 32'(cyc - prev), 32'd17);
                    prev = cyc;
                end
            end
        join
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
